// File: rtl/acq_pkg.sv
// Shared types and constants for the oscilloscope capture controller.
// Default widths and trigger-edge encoding used by the controller and its trigger detector.
package acq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE_FILL  = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } acq_state_t;

   localparam logic EDGE_RISE = 1'b0;
   localparam logic EDGE_FALL = 1'b1;

   localparam int ACQ_ADDR_W = 12;
   localparam int ACQ_DATA_W = 8;

endpackage

// File: rtl/acq_trig_detect.sv
// Level/edge trigger detector: remembers the previous sample of the current capture and
// flags a crossing of trig_level on the sample presented with sample_valid.
module acq_trig_detect
   import acq_pkg::*;
#(
   parameter int DATA_W = ACQ_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              en,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_edge,
   output logic              hit
);

   logic [DATA_W-1:0] prev_sample;
   logic              prev_valid;

   always_comb begin
      hit = 1'b0;
      if (sample_valid && prev_valid) begin
         if (trig_edge == EDGE_RISE)
            hit = (prev_sample < trig_level) && (sample >= trig_level);
         else
            hit = (prev_sample > trig_level) && (sample <= trig_level);
      end
   end

   // A fresh capture must not compare against a sample left over from the previous one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_sample <= '0;
         prev_valid  <= 1'b0;
      end else if (clear) begin
         prev_valid  <= 1'b0;
      end else if (en && sample_valid) begin
         prev_sample <= sample;
         prev_valid  <= 1'b1;
      end
   end

endmodule

// File: rtl/acq_capture_ctrl.sv
// Capture sequencer: arm, pre-trigger fill, trigger search, post-trigger fill, done.
// Drives the write port of a circular capture RAM and reports trigger/start addresses.
module acq_capture_ctrl
   import acq_pkg::*;
#(
   parameter int ADDR_W = ACQ_ADDR_W,
   parameter int DATA_W = ACQ_DATA_W,
   parameter int TO_W   = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample,
   input  logic              arm,
   input  logic              abort,
   input  logic              force_trig,
   input  logic              ack,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_edge,
   input  logic              auto_en,
   input  logic [TO_W-1:0]   auto_timeout,
   input  logic [ADDR_W-1:0] pre_depth,
   input  logic [ADDR_W-1:0] post_depth,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W-1:0] start_addr,
   output logic              trig_forced,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   acq_state_t        state;
   logic [ADDR_W-1:0] pre_len;
   logic [ADDR_W-1:0] post_len;
   logic [ADDR_W-1:0] fill_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              force_pend;

   logic              in_capture;
   logic              arm_ok;
   logic [ADDR_W-1:0] pre_room;
   logic [ADDR_W-1:0] post_clamp;
   logic [ADDR_W-1:0] next_addr;
   logic              level_hit;
   logic              force_hit;
   logic              auto_hit;
   logic              trig_hit;

   assign in_capture = (state == ST_PRE_FILL) || (state == ST_WAIT_TRIG) || (state == ST_POST);
   assign busy       = in_capture;
   assign done       = (state == ST_DONE);
   assign arm_ok     = arm && !in_capture && !abort;

   // pre_depth already fits in DEPTH-1; only post needs trimming so pre+post stays below DEPTH.
   assign pre_room   = LAST_IDX - pre_depth;
   assign post_clamp = (post_depth > pre_room) ? pre_room : post_depth;

   // Address the current sample will land on, accounting for a write still in flight.
   assign next_addr  = wr_addr + ADDR_W'(wr_en);

   assign force_hit  = force_trig || force_pend;
   assign auto_hit   = auto_en && (to_cnt == auto_timeout);
   assign trig_hit   = level_hit || force_hit || auto_hit;

   acq_trig_detect #(
      .DATA_W(DATA_W)
   ) u_trig_detect (
      .clk         (clk),
      .rst         (rst),
      .clear       (arm_ok),
      .en          (in_capture),
      .sample_valid(sample_valid),
      .sample      (sample),
      .trig_level  (trig_level),
      .trig_edge   (trig_edge),
      .hit         (level_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         trig_addr   <= '0;
         start_addr  <= '0;
         trig_forced <= 1'b0;
         pre_len     <= '0;
         post_len    <= '0;
         fill_cnt    <= '0;
         to_cnt      <= '0;
         force_pend  <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (wr_en)
            wr_addr <= wr_addr + ONE;

         if (abort) begin
            state      <= ST_IDLE;
            force_pend <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (arm) begin
                     pre_len     <= pre_depth;
                     post_len    <= post_clamp;
                     wr_addr     <= '0;
                     fill_cnt    <= '0;
                     to_cnt      <= '0;
                     trig_forced <= 1'b0;
                     force_pend  <= 1'b0;
                     state       <= (pre_depth == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
                  end else if (state == ST_DONE && ack) begin
                     state <= ST_IDLE;
                  end
               end

               ST_PRE_FILL: begin
                  if (sample_valid) begin
                     wr_en   <= 1'b1;
                     wr_data <= sample;
                     if (fill_cnt + ONE == pre_len) begin
                        fill_cnt <= '0;
                        state    <= ST_WAIT_TRIG;
                     end else begin
                        fill_cnt <= fill_cnt + ONE;
                     end
                  end
               end

               ST_WAIT_TRIG: begin
                  if (sample_valid) begin
                     wr_en   <= 1'b1;
                     wr_data <= sample;
                     to_cnt  <= to_cnt + TO_W'(1);
                     if (trig_hit) begin
                        trig_addr   <= next_addr;
                        start_addr  <= next_addr - pre_len;
                        trig_forced <= force_hit || auto_hit;
                        force_pend  <= 1'b0;
                        fill_cnt    <= '0;
                        state       <= (post_len == '0) ? ST_DONE : ST_POST;
                     end
                  end else if (force_trig) begin
                     force_pend <= 1'b1;
                  end
               end

               ST_POST: begin
                  if (sample_valid) begin
                     wr_en   <= 1'b1;
                     wr_data <= sample;
                     if (fill_cnt + ONE == post_len) begin
                        fill_cnt <= '0;
                        state    <= ST_DONE;
                     end else begin
                        fill_cnt <= fill_cnt + ONE;
                     end
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Randomised bench for acq_capture_ctrl (ADDR_W=4) with a sample-index reference model
// of where the trigger lands and which samples end up in the buffer.
module tb_acq_capture_ctrl;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int TW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          sample_valid;
   logic [DW-1:0] sample;
   logic          arm;
   logic          abort;
   logic          force_trig;
   logic          ack;
   logic [DW-1:0] trig_level;
   logic          trig_edge;
   logic          auto_en;
   logic [TW-1:0] auto_timeout;
   logic [AW-1:0] pre_depth;
   logic [AW-1:0] post_depth;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] trig_addr;
   logic [AW-1:0] start_addr;
   logic          trig_forced;
   logic          busy;
   logic          done;

   acq_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TO_W(TW)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
      .arm(arm), .abort(abort), .force_trig(force_trig), .ack(ack),
      .trig_level(trig_level), .trig_edge(trig_edge), .auto_en(auto_en),
      .auto_timeout(auto_timeout), .pre_depth(pre_depth), .post_depth(post_depth),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .trig_addr(trig_addr),
      .start_addr(start_addr), .trig_forced(trig_forced), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int checks = 0;

   logic [DW-1:0] smp [64];
   bit            fr  [64];
   int            n;
   int            wa_q [$];
   int            wd_q [$];

   always @(negedge clk) begin
      if (wr_en) begin
         wa_q.push_back(int'(wr_addr));
         wd_q.push_back(int'(wr_data));
      end
   end

   // Reference: sample i of the capture lands at address i mod DEPTH; the trigger is the
   // first sample at index >= pre that crosses the level, carries force, or hits the timeout.
   task automatic model(input int pre, input int post, input int edg, input int lvl,
                        input int aen, input int tmo,
                        output int t, output bit fo, output int nw, output bit dn);
      int pc;
      bit lv;
      pc = (post > DEPTH - 1 - pre) ? DEPTH - 1 - pre : post;
      t  = -1;
      fo = 1'b0;
      for (int i = pre; i < n; i++) begin
         lv = 1'b0;
         if (i > 0) begin
            if (edg == 0) lv = (int'(smp[i-1]) < lvl) && (int'(smp[i]) >= lvl);
            else          lv = (int'(smp[i-1]) > lvl) && (int'(smp[i]) <= lvl);
         end
         if (lv || fr[i] || (aen != 0 && (i - pre) == tmo)) begin
            t  = i;
            fo = fr[i] || (aen != 0 && (i - pre) == tmo);
            break;
         end
      end
      if (t < 0) begin
         nw = n;
         dn = 1'b0;
      end else begin
         nw = (t + pc + 1 < n) ? t + pc + 1 : n;
         dn = (t + pc < n);
      end
   endtask

   task automatic play_capture(input int pre, input int post, input int edg, input int lvl,
                               input int aen, input int tmo);
      int gap;
      pre_depth    = AW'(pre);
      post_depth   = AW'(post);
      trig_edge    = 1'(edg);
      trig_level   = DW'(lvl);
      auto_en      = 1'(aen);
      auto_timeout = TW'(tmo);
      wa_q.delete();
      wd_q.delete();
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      for (int i = 0; i < n; i++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) begin @(posedge clk); #1; end
         sample_valid = 1'b1;
         sample       = smp[i];
         force_trig   = fr[i];
         @(posedge clk); #1;
         sample_valid = 1'b0;
         force_trig   = 1'b0;
      end
      repeat (4) begin @(posedge clk); #1; end
   endtask

   task automatic clear_stim(input int len, input int val);
      n = len;
      for (int i = 0; i < 64; i++) begin
         smp[i] = DW'(val);
         fr[i]  = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sample_valid = 0; sample = 0; arm = 0; abort = 0; force_trig = 0; ack = 0;
      trig_level = 0; trig_edge = 0; auto_en = 0; auto_timeout = 0;
      pre_depth = 0; post_depth = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({wr_en, wr_addr, wr_data, trig_addr, start_addr, trig_forced} !== '0)
         $display("FAIL reset_outputs: got wr_en=%0b wr_addr=%0d wr_data=%0h trig=%0d start=%0d forced=%0b, want all 0",
                  wr_en, wr_addr, wr_data, trig_addr, start_addr, trig_forced);
      else passed++;
      checks++;
      if ({busy, done} !== 2'b00) $display("FAIL reset_state: got busy=%0b done=%0b want 0 0", busy, done);
      else passed++;
   endtask

   task automatic test_rising();
      int t, nw; bit fo, dn;
      clear_stim(10, 0);
      for (int i = 0; i < 10; i++) smp[i] = DW'(8'h70 + 4 * i);
      play_capture(3, 4, 0, 8'h80, 0, 0);
      model(3, 4, 0, 8'h80, 0, 0, t, fo, nw, dn);
      checks++;
      if (wa_q.size() !== nw) $display("FAIL rise_writes: got %0d want %0d", wa_q.size(), nw);
      else passed++;
      for (int k = 0; k < wa_q.size() && k < nw; k++) begin
         checks++;
         if (wa_q[k] !== k % DEPTH || wd_q[k] !== int'(smp[k]))
            $display("FAIL rise_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h",
                     k, wa_q[k], wd_q[k], k % DEPTH, smp[k]);
         else passed++;
      end
      checks++;
      if (int'(trig_addr) !== t % DEPTH || int'(start_addr) !== (t - 3) % DEPTH)
         $display("FAIL rise_addrs: got trig=%0d start=%0d want trig=%0d start=%0d",
                  trig_addr, start_addr, t % DEPTH, (t - 3) % DEPTH);
      else passed++;
      checks++;
      if (done !== dn || busy !== 1'b0 || trig_forced !== fo)
         $display("FAIL rise_status: got done=%0b busy=%0b forced=%0b want %0b 0 %0b", done, busy, trig_forced, dn, fo);
      else passed++;
   endtask

   task automatic test_falling();
      int t, nw; bit fo, dn;
      clear_stim(9, 8'h30);
      smp[0] = 8'h40; smp[1] = 8'h40; smp[2] = 8'h50; smp[3] = 8'h45; smp[4] = 8'h40;
      play_capture(0, 2, 1, 8'h40, 0, 0);
      model(0, 2, 1, 8'h40, 0, 0, t, fo, nw, dn);
      checks++;
      if (int'(trig_addr) !== t % DEPTH) $display("FAIL fall_trig: got %0d want %0d", trig_addr, t % DEPTH);
      else passed++;
      checks++;
      if (wa_q.size() !== nw || done !== dn || trig_forced !== fo)
         $display("FAIL fall_status: got writes=%0d done=%0b forced=%0b want %0d %0b %0b",
                  wa_q.size(), done, trig_forced, nw, dn, fo);
      else passed++;
   endtask

   task automatic test_auto();
      int t, nw; bit fo, dn;
      clear_stim(14, 8'h10);
      fr[1] = 1'b1;
      play_capture(2, 3, 0, 8'h80, 1, 5);
      model(2, 3, 0, 8'h80, 1, 5, t, fo, nw, dn);
      checks++;
      if (int'(trig_addr) !== t % DEPTH || trig_forced !== 1'b1)
         $display("FAIL auto_trig: got trig=%0d forced=%0b want %0d 1", trig_addr, trig_forced, t % DEPTH);
      else passed++;
      checks++;
      if (wa_q.size() !== nw || done !== dn)
         $display("FAIL auto_status: got writes=%0d done=%0b want %0d %0b", wa_q.size(), done, nw, dn);
      else passed++;
   endtask

   task automatic test_wrap();
      int t, nw; bit fo, dn;
      clear_stim(26, 8'h20);
      for (int i = 0; i < 26; i++) smp[i] = DW'(i);
      fr[20] = 1'b1;
      play_capture(10, 3, 0, 8'hff, 0, 0);
      model(10, 3, 0, 8'hff, 0, 0, t, fo, nw, dn);
      checks++;
      if (int'(trig_addr) !== t % DEPTH || int'(start_addr) !== (t - 10) % DEPTH)
         $display("FAIL wrap_addrs: got trig=%0d start=%0d want %0d %0d", trig_addr, start_addr, t % DEPTH, (t - 10) % DEPTH);
      else passed++;
      checks++;
      if (wa_q.size() !== nw || wa_q[16] !== 0 || wd_q[16] !== 16)
         $display("FAIL wrap_writes: got count=%0d addr16=%0d want %0d 0", wa_q.size(), wa_q[16], nw);
      else passed++;
      clear_stim(20, 8'h20);
      fr[16] = 1'b1;
      play_capture(15, 9, 0, 8'hff, 0, 0);
      model(15, 9, 0, 8'hff, 0, 0, t, fo, nw, dn);
      checks++;
      if (wa_q.size() !== nw || done !== dn || int'(start_addr) !== (t - 15) % DEPTH)
         $display("FAIL clamp_post: got writes=%0d done=%0b start=%0d want %0d %0b %0d",
                  wa_q.size(), done, start_addr, nw, dn, (t - 15) % DEPTH);
      else passed++;
   endtask

   task automatic test_abort_arm();
      clear_stim(5, 8'h55);
      fr[2] = 1'b1;
      play_capture(2, 10, 0, 8'hff, 0, 0);
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
      sample_valid = 1'b1; sample = 8'h66;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (wa_q.size() !== 6 || wa_q[5] !== 5 || busy !== 1'b1)
         $display("FAIL arm_ignored: got writes=%0d last_addr=%0d busy=%0b want 6 5 1",
                  wa_q.size(), wa_q[wa_q.size()-1], busy);
      else passed++;
      abort = 1'b1; arm = 1'b1; sample_valid = 1'b1; sample = 8'h77;
      @(posedge clk); #1;
      abort = 1'b0; arm = 1'b0; sample_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || trig_addr !== AW'(2))
         $display("FAIL abort: got busy=%0b done=%0b wr_en=%0b trig=%0d want 0 0 0 2", busy, done, wr_en, trig_addr);
      else passed++;
      clear_stim(4, 8'h11);
      fr[1] = 1'b1;
      play_capture(1, 1, 0, 8'hff, 0, 0);
      checks++;
      if (wa_q.size() !== 3 || wa_q[0] !== 0 || done !== 1'b1)
         $display("FAIL rearm: got writes=%0d first_addr=%0d done=%0b want 3 0 1", wa_q.size(), wa_q[0], done);
      else passed++;
   endtask

   task automatic test_async_rst_ack();
      clear_stim(3, 8'h99);
      play_capture(1, 2, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, wr_en, wr_addr, wr_data, trig_addr, start_addr, trig_forced} !== '0)
         $display("FAIL async_rst: got busy=%0b wr_addr=%0d wr_data=%0h trig=%0d want all 0",
                  busy, wr_addr, wr_data, trig_addr);
      else passed++;
      #1 rst = 1'b0;
      clear_stim(3, 8'h22);
      fr[0] = 1'b1;
      play_capture(0, 1, 0, 8'hff, 0, 0);
      checks++;
      if (done !== 1'b1) $display("FAIL ack_pre: got done=%0b want 1", done);
      else passed++;
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL ack: got done=%0b busy=%0b want 0 0", done, busy);
      else passed++;
   endtask

   task automatic test_random();
      int t, nw, pre, post, edg, lvl, aen, tmo;
      bit fo, dn;
      for (int it = 0; it < 12; it++) begin
         n = 40;
         for (int i = 0; i < 64; i++) begin
            smp[i] = DW'($urandom_range(0, 255));
            fr[i]  = ($urandom_range(0, 15) == 0);
         end
         pre  = $urandom_range(0, 15);
         post = $urandom_range(0, 15);
         edg  = $urandom_range(0, 1);
         lvl  = $urandom_range(1, 254);
         aen  = $urandom_range(0, 1);
         tmo  = $urandom_range(0, 10);
         play_capture(pre, post, edg, lvl, aen, tmo);
         model(pre, post, edg, lvl, aen, tmo, t, fo, nw, dn);
         checks++;
         if (wa_q.size() !== nw) $display("FAIL rnd%0d_writes: got %0d want %0d", it, wa_q.size(), nw);
         else passed++;
         for (int k = 0; k < wa_q.size() && k < nw; k++) begin
            checks++;
            if (wa_q[k] !== k % DEPTH || wd_q[k] !== int'(smp[k]))
               $display("FAIL rnd%0d_write%0d: got addr=%0d data=%0h want addr=%0d data=%0h",
                        it, k, wa_q[k], wd_q[k], k % DEPTH, smp[k]);
            else passed++;
         end
         checks++;
         if (done !== dn || busy !== !dn) $display("FAIL rnd%0d_state: got done=%0b busy=%0b want %0b %0b", it, done, busy, dn, !dn);
         else passed++;
         if (t >= 0) begin
            checks++;
            if (int'(trig_addr) !== t % DEPTH || int'(start_addr) !== (t - pre) % DEPTH || trig_forced !== fo)
               $display("FAIL rnd%0d_trig: got trig=%0d start=%0d forced=%0b want %0d %0d %0b",
                        it, trig_addr, start_addr, trig_forced, t % DEPTH, (t - pre) % DEPTH, fo);
            else passed++;
         end
         if (!dn) begin
            abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
         end else if ($urandom_range(0, 1) == 1) begin
            ack = 1'b1; @(posedge clk); #1; ack = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_rising();
      test_falling();
      test_auto();
      test_wrap();
      test_abort_arm();
      test_async_rst_ack();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
